// File: rtl/buzzer_arbiter_n.sv
// N-player quiz buzz-in arbiter with edge-qualified presses, judge handshake and rebound.
// Define ROUND_ROBIN_EN for a rotating tie-break pointer; default is lowest-index-wins.
module buzzer_arbiter_n #(
  parameter int unsigned N_PLAYERS    = 4,
  parameter int unsigned PULSE_CYCLES = 25_000_000,
  localparam int unsigned PN_W        = $clog2(N_PLAYERS + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Arm,
  input  logic [N_PLAYERS-1:0] Keys,
  input  logic                 TimeOver_Block,
  input  logic                 Judge_Valid,
  input  logic                 Judge_Correct,
  output logic [N_PLAYERS-1:0] LED_Out,
  output logic [PN_W-1:0]      Player_Number,
  output logic                 Timer_Start,
  output logic                 Buzzer_Answer,
  output logic                 Answer_true,
  output logic [N_PLAYERS-1:0] Excluded
);

  localparam int unsigned IDX_W = $clog2(N_PLAYERS);
  localparam int unsigned CNT_W = $clog2(PULSE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StArmed, StLocked, StWin, StPenalty, StDone} state_e;

  state_e               state_q, state_d;
  logic [N_PLAYERS-1:0] keys_q;
  logic [N_PLAYERS-1:0] led_q, led_d;
  logic [PN_W-1:0]      pn_q, pn_d;
  logic                 timer_q, timer_d;
  logic                 buzz_q, buzz_d;
  logic                 ans_q, ans_d;
  logic [N_PLAYERS-1:0] excl_q, excl_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [N_PLAYERS-1:0] eligible;
  logic                 found;
  logic                 capture;
  logic [IDX_W-1:0]     win_idx;

  // A press is a 1->0 transition; a key already held low never qualifies.
  assign eligible = keys_q & ~Keys & ~excl_q;

`ifdef ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W:0]   rr_sum;

  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    rr_sum  = '0;
    for (int k = 0; k < N_PLAYERS; k++) begin
      rr_sum = {1'b0, ptr_q} + (IDX_W + 1)'(k);
      if (rr_sum >= (IDX_W + 1)'(N_PLAYERS)) rr_sum = rr_sum - (IDX_W + 1)'(N_PLAYERS);
      if (!found && eligible[rr_sum[IDX_W-1:0]]) begin
        found   = 1'b1;
        win_idx = rr_sum[IDX_W-1:0];
      end
    end
  end

  // Pointer survives Arm=0 so fairness carries across rounds.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q <= '0;
    end else if (capture) begin
      ptr_q <= (win_idx == IDX_W'(N_PLAYERS - 1)) ? '0 : win_idx + IDX_W'(1);
    end
  end
`else
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (!found && eligible[IDX_W'(i)]) begin
        found   = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    pn_d    = pn_q;
    timer_d = timer_q;
    buzz_d  = buzz_q;
    ans_d   = ans_q;
    excl_d  = excl_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (!Arm) begin
      state_d = StIdle;
      led_d   = '0;
      pn_d    = '0;
      timer_d = 1'b0;
      buzz_d  = 1'b0;
      ans_d   = 1'b0;
      excl_d  = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StArmed;
        StArmed: begin
          if (!TimeOver_Block && found) begin
            capture = 1'b1;
            led_d   = {{(N_PLAYERS - 1){1'b0}}, 1'b1} << win_idx;
            pn_d    = PN_W'(win_idx) + PN_W'(1);
            timer_d = 1'b1;
            state_d = StLocked;
          end
        end
        StLocked: begin
          // A verdict outranks a timeout arriving in the same cycle.
          if (Judge_Valid && Judge_Correct) begin
            ans_d   = 1'b1;
            cnt_d   = '0;
            state_d = StWin;
          end else if (Judge_Valid || TimeOver_Block) begin
            buzz_d  = 1'b1;
            excl_d  = excl_q | led_q;
            cnt_d   = '0;
            state_d = StPenalty;
          end
        end
        StWin: begin
          if (cnt_q == CNT_LAST) begin
            ans_d   = 1'b0;
            timer_d = 1'b0;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StPenalty: begin
          if (cnt_q == CNT_LAST) begin
            buzz_d  = 1'b0;
            led_d   = '0;
            pn_d    = '0;
            timer_d = 1'b0;
            state_d = (&excl_q) ? StDone : StArmed;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StDone: state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      keys_q  <= '1;
      led_q   <= '0;
      pn_q    <= '0;
      timer_q <= 1'b0;
      buzz_q  <= 1'b0;
      ans_q   <= 1'b0;
      excl_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      keys_q  <= Keys;
      led_q   <= led_d;
      pn_q    <= pn_d;
      timer_q <= timer_d;
      buzz_q  <= buzz_d;
      ans_q   <= ans_d;
      excl_q  <= excl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign LED_Out       = led_q;
  assign Player_Number = pn_q;
  assign Timer_Start   = timer_q;
  assign Buzzer_Answer = buzz_q;
  assign Answer_true   = ans_q;
  assign Excluded      = excl_q;

endmodule

// File: tb/tb_buzzer_arbiter_n.sv
// Scoreboard bench for buzzer_arbiter_n (N=4, PULSE_CYCLES=4); directed vectors,
// expected output snapshots queued by stimulus and checked by a negedge monitor.
module tb_buzzer_arbiter_n;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Arm;
  logic [3:0] Keys;
  logic       TimeOver_Block;
  logic       Judge_Valid;
  logic       Judge_Correct;
  logic [3:0] LED_Out;
  logic [2:0] Player_Number;
  logic       Timer_Start;
  logic       Buzzer_Answer;
  logic       Answer_true;
  logic [3:0] Excluded;

  buzzer_arbiter_n #(
    .N_PLAYERS   (4),
    .PULSE_CYCLES(4)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .Arm           (Arm),
    .Keys          (Keys),
    .TimeOver_Block(TimeOver_Block),
    .Judge_Valid   (Judge_Valid),
    .Judge_Correct (Judge_Correct),
    .LED_Out       (LED_Out),
    .Player_Number (Player_Number),
    .Timer_Start   (Timer_Start),
    .Buzzer_Answer (Buzzer_Answer),
    .Answer_true   (Answer_true),
    .Excluded      (Excluded)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         cyc;
    string      name;
    logic [3:0] led;
    logic [2:0] pn;
    logic       ts;
    logic       bz;
    logic       at;
    logic [3:0] ex;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: every entry due in this cycle is compared against the live outputs.
  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      cur = sb.pop_front();
      checks++;
      if (cur.cyc != cyc ||
          {LED_Out, Player_Number, Timer_Start, Buzzer_Answer, Answer_true, Excluded} !==
          {cur.led, cur.pn, cur.ts, cur.bz, cur.at, cur.ex}) begin
        errors++;
        $display("FAIL %s cyc=%0d/%0d got led=%b pn=%0d ts=%b bz=%b at=%b ex=%b want led=%b pn=%0d ts=%b bz=%b at=%b ex=%b",
                 cur.name, cyc, cur.cyc, LED_Out, Player_Number, Timer_Start, Buzzer_Answer,
                 Answer_true, Excluded, cur.led, cur.pn, cur.ts, cur.bz, cur.at, cur.ex);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_now(input string name, input logic [3:0] led, input logic [2:0] pn,
                           input logic ts, input logic bz, input logic at, input logic [3:0] ex);
    checks++;
    if ({LED_Out, Player_Number, Timer_Start, Buzzer_Answer, Answer_true, Excluded} !==
        {led, pn, ts, bz, at, ex}) begin
      errors++;
      $display("FAIL %s got led=%b pn=%0d ts=%b bz=%b at=%b ex=%b want led=%b pn=%0d ts=%b bz=%b at=%b ex=%b",
               name, LED_Out, Player_Number, Timer_Start, Buzzer_Answer, Answer_true, Excluded,
               led, pn, ts, bz, at, ex);
    end
  endtask

  task automatic expect_out(input string name, input logic [3:0] led, input logic [2:0] pn,
                            input logic ts, input logic bz, input logic at, input logic [3:0] ex);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.led  = led;
    e.pn   = pn;
    e.ts   = ts;
    e.bz   = bz;
    e.at   = at;
    e.ex   = ex;
    sb.push_back(e);
  endtask

  // Press then release, so the next press is a fresh falling edge.
  task automatic press(input logic [3:0] k);
    Keys = k;
    tick();
    Keys = 4'b1111;
    tick();
  endtask

  // Verdict inputs already driven by the caller.
  task automatic wrong_pulse(input string name, input logic [3:0] led, input logic [2:0] pn,
                             input logic [3:0] ex_after);
    tick();
    Judge_Valid    = 1'b0;
    TimeOver_Block = 1'b0;
    for (int c = 0; c < 4; c++) begin
      expect_out(name, led, pn, 1'b1, 1'b1, 1'b0, ex_after);
      tick();
    end
    expect_out({name, "_end"}, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, ex_after);
  endtask

  task automatic win_pulse(input string name, input logic [3:0] led, input logic [2:0] pn,
                           input logic [3:0] ex);
    tick();
    Judge_Valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      expect_out(name, led, pn, 1'b1, 1'b0, 1'b1, ex);
      tick();
    end
    expect_out({name, "_done"}, led, pn, 1'b0, 1'b0, 1'b0, ex);
  endtask

  initial begin
    RST = 1'b1; Arm = 1'b0; Keys = 4'b1111;
    TimeOver_Block = 1'b0; Judge_Valid = 1'b0; Judge_Correct = 1'b0;
    tick();
    tick();
    check_now("reset_now", 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    expect_out("reset", 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000);

    // 1: single press, correct answer
    RST = 1'b0; Arm = 1'b1;
    tick();
    expect_out("s1_armed", 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    press(4'b1101);
    expect_out("s1_capture", 4'b0010, 3'd2, 1'b1, 1'b0, 1'b0, 4'b0000);
    Judge_Valid = 1'b1; Judge_Correct = 1'b1;
    win_pulse("s1_win", 4'b0010, 3'd2, 4'b0000);
    press(4'b1110);
    expect_out("s1_done_hold", 4'b0010, 3'd2, 1'b0, 1'b0, 1'b0, 4'b0000);
    Arm = 1'b0;
    tick();
    expect_out("s1_abort", 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000);

    // 2: simultaneous press tie-break, from a fresh reset
    RST = 1'b1;
    tick();
    RST = 1'b0; Arm = 1'b1;
    tick();
    press(4'b0101);
    expect_out("s2_tie", 4'b0010, 3'd2, 1'b1, 1'b0, 1'b0, 4'b0000);
    Arm = 1'b0;
    tick();
    expect_out("s2_abort", 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    Arm = 1'b1;
    tick();
    press(4'b0101);
`ifdef ROUND_ROBIN_EN
    expect_out("s2_round2", 4'b1000, 3'd4, 1'b1, 1'b0, 1'b0, 4'b0000);
`else
    expect_out("s2_round2", 4'b0010, 3'd2, 1'b1, 1'b0, 1'b0, 4'b0000);
`endif

    // 3: rebound after a wrong answer
    Arm = 1'b0;
    tick();
    Arm = 1'b1;
    tick();
    press(4'b1110);
    expect_out("s3_p1", 4'b0001, 3'd1, 1'b1, 1'b0, 1'b0, 4'b0000);
    Judge_Valid = 1'b1; Judge_Correct = 1'b0;
    wrong_pulse("s3_wrong", 4'b0001, 3'd1, 4'b0001);
    press(4'b1110);
    expect_out("s3_excl_ignored", 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0001);
    press(4'b1011);
    expect_out("s3_p3", 4'b0100, 3'd3, 1'b1, 1'b0, 1'b0, 4'b0001);

    // 4: everyone wrong -> DONE
    Judge_Valid = 1'b1; Judge_Correct = 1'b0;
    wrong_pulse("s4_p3", 4'b0100, 3'd3, 4'b0101);
    press(4'b1101);
    expect_out("s4_cap_p2", 4'b0010, 3'd2, 1'b1, 1'b0, 1'b0, 4'b0101);
    Judge_Valid = 1'b1;
    wrong_pulse("s4_p2", 4'b0010, 3'd2, 4'b0111);
    press(4'b0111);
    expect_out("s4_cap_p4", 4'b1000, 3'd4, 1'b1, 1'b0, 1'b0, 4'b0111);
    Judge_Valid = 1'b1;
    wrong_pulse("s4_p4", 4'b1000, 3'd4, 4'b1111);
    press(4'b0000);
    expect_out("s4_done_ignore", 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 4'b1111);
    Arm = 1'b0;
    tick();
    expect_out("s4_clear", 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000);

    // 5: TimeOver_Block behaviour
    Arm = 1'b1;
    tick();
    TimeOver_Block = 1'b1;
    press(4'b1110);
    expect_out("s5_tob_block", 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    TimeOver_Block = 1'b0;
    press(4'b1110);
    expect_out("s5_cap", 4'b0001, 3'd1, 1'b1, 1'b0, 1'b0, 4'b0000);
    TimeOver_Block = 1'b1;
    wrong_pulse("s5_timeout", 4'b0001, 3'd1, 4'b0001);
    press(4'b1101);
    expect_out("s5_cap2", 4'b0010, 3'd2, 1'b1, 1'b0, 1'b0, 4'b0001);
    Judge_Valid = 1'b1; Judge_Correct = 1'b1; TimeOver_Block = 1'b1;
    tick();
    Judge_Valid = 1'b0; TimeOver_Block = 1'b0;
    expect_out("s5_jv_priority", 4'b0010, 3'd2, 1'b1, 1'b0, 1'b1, 4'b0001);
    Arm = 1'b0;
    tick();
    expect_out("s5_abort_win", 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000);

    // 6: held key, reset mid-pulse, abort in LOCKED
    Keys = 4'b1110;
    tick();
    Arm = 1'b1;
    tick();
    tick();
    expect_out("s6_held", 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    Keys = 4'b1111;
    tick();
    press(4'b1011);
    expect_out("s6_cap", 4'b0100, 3'd3, 1'b1, 1'b0, 1'b0, 4'b0000);
    Judge_Valid = 1'b1; Judge_Correct = 1'b0;
    tick();
    Judge_Valid = 1'b0;
    expect_out("s6_buzz", 4'b0100, 3'd3, 1'b1, 1'b1, 1'b0, 4'b0100);
    tick();
    RST = 1'b1;
    tick();
    expect_out("s6_rst", 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    RST = 1'b0;
    tick();
    press(4'b1110);
    expect_out("s6_after_rst", 4'b0001, 3'd1, 1'b1, 1'b0, 1'b0, 4'b0000);
    Arm = 1'b0;
    tick();
    expect_out("s6_abort_locked", 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000);

    tick();
    tick();
    // Anything still queued never came due: an expired wait.
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain %0d expectation(s) never checked", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/buzzer_arbiter_n.md
Name: buzzer_arbiter_n

Overview:
- Parametrised N-player quiz buzz-in arbiter; successor to the fixed 4-player selector.
- Sits between debounced player keys, the host round control and the answer timer; drives player LEDs, player-number display, buzzer and correct-answer indicator.
- New behaviour:
  - configurable player count and pulse length
  - edge-qualified presses
  - explicit judge handshake
  - rebound: a wrongly answering player is excluded and the round re-arms for the rest.

Parameters:
N_PLAYERS, 4, number of player keys (2..16)
PULSE_CYCLES, 25_000_000, length in CLK cycles of Buzzer_Answer / Answer_true pulses (>=1)
PN_W, $clog2(N_PLAYERS+1), width of Player_Number (localparam, derived)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-high
Arm  in  1  host round enable; 1 = round open, 0 = abort/clear
Keys  in  N_PLAYERS  player keys, active-low, already synchronised and debounced
TimeOver_Block  in  1  answer timer expired / capture inhibit
Judge_Valid  in  1  one-cycle verdict strobe
Judge_Correct  in  1  verdict, sampled when Judge_Valid=1
LED_Out  out  N_PLAYERS  one-hot winner LED
Player_Number  out  PN_W  winner index+1; 0 = none
Timer_Start  out  1  high while a winner holds the floor
Buzzer_Answer  out  1  wrong-answer pulse
Answer_true  out  1  correct-answer pulse
Excluded  out  N_PLAYERS  players locked out this round

Behaviour:
- One clock; reset is synchronous and active-high (RST sampled on posedge CLK).
- RST=1 → all outputs 0, state IDLE, pulse counter 0, Keys_q all 1s; RST overrides every state, including mid-pulse.
- Keys_q: registered copy of Keys every cycle. Press event for player i = Keys_q[i]=1 and Keys[i]=0. A held key never wins.
- Arm=0 in any state → next cycle IDLE; LED_Out, Player_Number, Timer_Start, Buzzer_Answer, Answer_true and Excluded are all cleared and the pulse counter is zeroed.
- States:
  - IDLE: outputs 0. Arm=1 → ARMED next cycle.
  - ARMED: eligible = press & ~Excluded.
    - Captures only when TimeOver_Block=0 and eligible≠0.
    - Winner w = lowest set index of eligible.
    - On capture, registered: LED_Out=1<<w, Player_Number=w+1, Timer_Start=1, next state LOCKED.
    - Presses in the capture cycle by other players are discarded.
    - Excluded players' presses are ignored.
  - LOCKED: holds outputs.
    - Judge_Valid=1 and Judge_Correct=1 → Answer_true=1, counter starts, next state WIN.
    - Judge_Valid=1 and Judge_Correct=0 → Buzzer_Answer=1, Excluded[w] set, counter starts, next state PENALTY.
    - TimeOver_Block=1 with no Judge_Valid in the same cycle → handled exactly as wrong. Judge_Valid has priority over TimeOver_Block.
    - Judge_Valid in any other state is ignored.
  - WIN: Answer_true high exactly PULSE_CYCLES cycles, then 0; counter stops at PULSE_CYCLES-1. Next state DONE after the pulse.
  - PENALTY: Buzzer_Answer high exactly PULSE_CYCLES cycles. On the last pulse cycle, LED_Out, Player_Number and Timer_Start clear on the following edge. Next state: DONE if Excluded is all 1s, else ARMED.
  - DONE: LED_Out/Player_Number hold (winner after WIN; 0 after all excluded). Leaves only via Arm=0.
- Counter width: $clog2(PULSE_CYCLES+1). PULSE_CYCLES=1 gives single-cycle pulses.
- Buzzer_Answer and Answer_true are never high in the same cycle.

Optional Feature:
- Macro ROUND_ROBIN_EN.
- Defined:
  - Tie-break uses a rotating priority pointer. After a capture by w, the pointer becomes (w+1) mod N_PLAYERS.
  - Search starts at the pointer and wraps.
  - The pointer resets to 0 on RST only; it persists across rounds and Arm=0.
- Undefined: fixed lowest-index-wins priority; no pointer register.

Test Plan:
Bench settings for all scenarios: N=4, PULSE_CYCLES=4.
1. RST, Arm=1, Keys=1101 falling from 1111 → one cycle later LED_Out=0010, Player_Number=2, Timer_Start=1. Judge_Valid=1/Correct=1 → Answer_true high 4 cycles, then DONE holding 0010/2.
2. Simultaneous press Keys 1111→0101 → winner player 2 (index 1), LED_Out=0010. With ROUND_ROBIN_EN, a second round with the same press → winner player 4, LED_Out=1000.
3. Rebound: player 1 wins, judged wrong → Buzzer_Answer 4 cycles, Excluded=0001, outputs clear. Player 1 re-presses → ignored. Player 3 presses → LED_Out=0100, Player_Number=3.
4. All four judged wrong in sequence → Excluded=1111, state DONE, LED_Out=0, Player_Number=0. Further presses ignored until Arm=0.
5. TimeOver_Block=1 in ARMED → press ignored. TimeOver_Block=1 in LOCKED → wrong-answer path (Buzzer 4 cycles, Excluded bit set). Judge_Valid with TimeOver_Block in the same cycle and Correct=1 → Answer_true.
6. Key held low before Arm rises → no capture. RST=1 mid-Buzzer pulse → next cycle all outputs 0. Arm=0 mid-LOCKED → IDLE, all outputs 0.
